sram_dual_port_arbiter: RTL and testbench

//  Shares one dual-port generic_sram among NREQ requesters, each with a

---
 rtl/sram_dual_port_arbiter.sv | 112 +++++++++++
 tb/tb_sram_dual_port_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_dual_port_arbiter.sv
// Round-robin arbiter sharing one dual-port SRAM among NREQ valid/ready requesters.
// Up to two non-conflicting grants per cycle (port 0 first); reads return through a registered response.
module sram_dual_port_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned abits = 10,
  parameter int unsigned dbits = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ-1:0]       req_we,
  input  logic [NREQ*abits-1:0] req_addr,
  input  logic [NREQ*dbits-1:0] req_wdata,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [NREQ*dbits-1:0] rsp_rdata,
  output logic [abits-1:0]      sram_a0,
  output logic [abits-1:0]      sram_a1,
  output logic [dbits-1:0]      sram_d0,
  output logic [dbits-1:0]      sram_d1,
  output logic                  sram_wen0,
  output logic                  sram_wen1,
  input  logic [dbits-1:0]      sram_q0,
  input  logic [dbits-1:0]      sram_q1
);

  localparam int unsigned IW = $clog2(NREQ);

  typedef struct packed {
    logic          vld;
    logic          is_read;
    logic [IW-1:0] idx;
  } tag_t;

  logic [IW-1:0] ptr;
  logic [IW-1:0] cand;
  logic          g0_vld;
  logic          g1_vld;
  logic [IW-1:0] g0;
  logic [IW-1:0] g1;
  tag_t          tag0;
  tag_t          tag1;

  // (base + k) mod NREQ without relying on a power-of-two NREQ
  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] base, input int unsigned k);
    int unsigned s;
    s = 32'(base) + k;
    if (s >= NREQ) s = s - NREQ;
    return IW'(s);
  endfunction

  // Scan from ptr: first valid wins port 0, next compatible valid wins port 1
  always_comb begin
    g0_vld = 1'b0;
    g1_vld = 1'b0;
    g0     = '0;
    g1     = '0;
    cand   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = wrap_inc(ptr, k);
      if (rstn && req_valid[cand]) begin
        if (!g0_vld) begin
          g0_vld = 1'b1;
          g0     = cand;
        end else if (!g1_vld &&
                     ((req_addr[32'(g0)*abits +: abits] != req_addr[32'(cand)*abits +: abits]) ||
                      !(req_we[g0] || req_we[cand]))) begin
          g1_vld = 1'b1;
          g1     = cand;
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (g0_vld) req_ready[g0] = 1'b1;
    if (g1_vld) req_ready[g1] = 1'b1;
  end

  assign sram_a0   = g0_vld ? req_addr[32'(g0)*abits +: abits]  : '0;
  assign sram_d0   = g0_vld ? req_wdata[32'(g0)*dbits +: dbits] : '0;
  assign sram_wen0 = g0_vld & req_we[g0];
  assign sram_a1   = g1_vld ? req_addr[32'(g1)*abits +: abits]  : '0;
  assign sram_d1   = g1_vld ? req_wdata[32'(g1)*dbits +: dbits] : '0;
  assign sram_wen1 = g1_vld & req_we[g1];

  // Pointer, per-port grant tags and read response registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr       <= '0;
      tag0      <= '0;
      tag1      <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
    end else begin
      if (g0_vld) ptr <= wrap_inc(g0, 1);
      tag0 <= '{vld: g0_vld, is_read: ~req_we[g0], idx: g0};
      tag1 <= '{vld: g1_vld, is_read: ~req_we[g1], idx: g1};
      rsp_valid <= '0;
      if (tag0.vld && tag0.is_read) begin
        rsp_valid[tag0.idx]                    <= 1'b1;
        rsp_rdata[32'(tag0.idx)*dbits +: dbits] <= sram_q0;
      end
      if (tag1.vld && tag1.is_read) begin
        rsp_valid[tag1.idx]                    <= 1'b1;
        rsp_rdata[32'(tag1.idx)*dbits +: dbits] <= sram_q1;
      end
    end
  end

endmodule

// File: tb/tb_sram_dual_port_arbiter.sv
// Bench for sram_dual_port_arbiter: directed vector table, hand sequences for reset,
// then random traffic checked against a queue-based reference model.
module tb_sram_dual_port_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned AB   = 10;
  localparam int unsigned DB   = 16;
  localparam int unsigned NVEC = 22;
  localparam int unsigned NRND = 300;

  logic                 clk;
  logic                 rstn;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ-1:0]      req_we;
  logic [NREQ*AB-1:0]   req_addr;
  logic [NREQ*DB-1:0]   req_wdata;
  logic [NREQ-1:0]      rsp_valid;
  logic [NREQ*DB-1:0]   rsp_rdata;
  logic [AB-1:0]        sram_a0, sram_a1;
  logic [DB-1:0]        sram_d0, sram_d1, sram_q0, sram_q1;
  logic                 sram_wen0, sram_wen1;

  int checks   = 0;
  int failures = 0;

  sram_dual_port_arbiter #(.NREQ(NREQ), .abits(AB), .dbits(DB)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .sram_a0(sram_a0), .sram_a1(sram_a1), .sram_d0(sram_d0), .sram_d1(sram_d1),
    .sram_wen0(sram_wen0), .sram_wen1(sram_wen1), .sram_q0(sram_q0), .sram_q1(sram_q1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] init_val(input int a);
    return 16'hC000 | 16'(a);
  endfunction

  // SRAM macro stand-in: registered q, read-before-write per port
  logic [DB-1:0] mem [1024];
  logic          mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int a = 0; a < 1024; a++) mem[a] <= init_val(a);
      mem_init <= 1'b1;
    end else begin
      sram_q0 <= mem[sram_a0];
      sram_q1 <= mem[sram_a1];
      if (sram_wen0) mem[sram_a0] <= sram_d0;
      if (sram_wen1) mem[sram_a1] <= sram_d1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] v, input logic [3:0] we, input logic [39:0] a,
                       input logic [63:0] wd);
    req_valid = v;
    req_we    = we;
    req_addr  = a;
    req_wdata = wd;
  endtask

  typedef struct {
    logic [3:0]  v;
    logic [3:0]  we;
    logic [39:0] addr;
    logic [63:0] wdata;
    logic [3:0]  rdy;
    logic [1:0]  wen;
    logic [9:0]  a0;
    logic [9:0]  a1;
    logic [15:0] d0;
    logic [15:0] d1;
    logic [3:0]  rv;
    logic [63:0] rd;
  } vec_t;

  vec_t vecs [NVEC];

  // Reference model state for the random phase
  logic [15:0] rmem [1024];
  logic [3:0]  sv [3];
  logic [15:0] sd [3][4];
  logic [15:0] exp_rd [4];
  logic        pv [4];
  logic        pwe [4];
  logic [9:0]  pa [4];
  logic [15:0] pd [4];
  int          mptr;
  int          waitq[$];
  int          g0m, g1m, slot, ns;
  logic [3:0]  exp_rdy;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    localparam logic [39:0] FA = {10'd19, 10'd18, 10'd17, 10'd16};
    vecs[0]  = '{4'b1111, 4'b0000, FA, 64'h0, 4'b0011, 2'b00, 10'd16, 10'd17, 16'h0, 16'h0, 4'b0000, 64'h0};
    vecs[1]  = '{4'b1111, 4'b0000, FA, 64'h0, 4'b0110, 2'b00, 10'd17, 10'd18, 16'h0, 16'h0, 4'b0000, 64'h0};
    vecs[2]  = '{4'b1111, 4'b0000, FA, 64'h0, 4'b1100, 2'b00, 10'd18, 10'd19, 16'h0, 16'h0, 4'b0011, 64'h0000_0000_C011_C010};
    vecs[3]  = '{4'b1111, 4'b0000, FA, 64'h0, 4'b1001, 2'b00, 10'd19, 10'd16, 16'h0, 16'h0, 4'b0110, 64'h0000_C012_C011_C010};
    vecs[4]  = '{4'b0000, 4'b0000, 40'h0, 64'h0, 4'b0000, 2'b00, 10'd0, 10'd0, 16'h0, 16'h0, 4'b1100, 64'hC013_C012_C011_C010};
    vecs[5]  = '{4'b0000, 4'b0000, 40'h0, 64'h0, 4'b0000, 2'b00, 10'd0, 10'd0, 16'h0, 16'h0, 4'b1001, 64'hC013_C012_C011_C010};
    vecs[6]  = '{4'b0100, 4'b0100, {10'd0, 10'd5, 20'd0}, 64'h0000_BEEF_0000_0000, 4'b0100, 2'b01, 10'd5, 10'd0, 16'hBEEF, 16'h0, 4'b0000, 64'hC013_C012_C011_C010};
    vecs[7]  = '{4'b0100, 4'b0000, {10'd0, 10'd5, 20'd0}, 64'h0, 4'b0100, 2'b00, 10'd5, 10'd0, 16'h0, 16'h0, 4'b0000, 64'hC013_C012_C011_C010};
    vecs[8]  = '{4'b0000, 4'b0000, 40'h0, 64'h0, 4'b0000, 2'b00, 10'd0, 10'd0, 16'h0, 16'h0, 4'b0000, 64'hC013_C012_C011_C010};
    vecs[9]  = '{4'b0000, 4'b0000, 40'h0, 64'h0, 4'b0000, 2'b00, 10'd0, 10'd0, 16'h0, 16'h0, 4'b0100, 64'hC013_BEEF_C011_C010};
    vecs[10] = '{4'b1000, 4'b0000, {10'd20, 30'd0}, 64'h0, 4'b1000, 2'b00, 10'd20, 10'd0, 16'h0, 16'h0, 4'b0000, 64'hC013_BEEF_C011_C010};
    vecs[11] = '{4'b0011, 4'b0001, {20'd0, 10'd7, 10'd7}, 64'h1234, 4'b0001, 2'b01, 10'd7, 10'd0, 16'h1234, 16'h0, 4'b0000, 64'hC013_BEEF_C011_C010};
    vecs[12] = '{4'b0010, 4'b0000, {20'd0, 10'd7, 10'd0}, 64'h0, 4'b0010, 2'b00, 10'd7, 10'd0, 16'h0, 16'h0, 4'b1000, 64'hC014_BEEF_C011_C010};
    vecs[13] = '{4'b0000, 4'b0000, 40'h0, 64'h0, 4'b0000, 2'b00, 10'd0, 10'd0, 16'h0, 16'h0, 4'b0000, 64'hC014_BEEF_C011_C010};
    vecs[14] = '{4'b0000, 4'b0000, 40'h0, 64'h0, 4'b0000, 2'b00, 10'd0, 10'd0, 16'h0, 16'h0, 4'b0010, 64'hC014_BEEF_1234_C010};
    vecs[15] = '{4'b0001, 4'b0001, {30'd0, 10'd9}, 64'h00AA, 4'b0001, 2'b01, 10'd9, 10'd0, 16'h00AA, 16'h0, 4'b0000, 64'hC014_BEEF_1234_C010};
    vecs[16] = '{4'b0011, 4'b0000, {20'd0, 10'd9, 10'd9}, 64'h0, 4'b0011, 2'b00, 10'd9, 10'd9, 16'h0, 16'h0, 4'b0000, 64'hC014_BEEF_1234_C010};
    vecs[17] = '{4'b0000, 4'b0000, 40'h0, 64'h0, 4'b0000, 2'b00, 10'd0, 10'd0, 16'h0, 16'h0, 4'b0000, 64'hC014_BEEF_1234_C010};
    vecs[18] = '{4'b0000, 4'b0000, 40'h0, 64'h0, 4'b0000, 2'b00, 10'd0, 10'd0, 16'h0, 16'h0, 4'b0011, 64'hC014_BEEF_00AA_00AA};
    vecs[19] = '{4'b1101, 4'b1000, {10'd9, 10'd9, 10'd0, 10'd30}, 64'h5555_0000_0000_0000, 4'b0101, 2'b00, 10'd9, 10'd30, 16'h0, 16'h0, 4'b0000, 64'hC014_BEEF_00AA_00AA};
    vecs[20] = '{4'b1000, 4'b1000, {10'd9, 30'd0}, 64'h5555_0000_0000_0000, 4'b1000, 2'b01, 10'd9, 10'd0, 16'h5555, 16'h0, 4'b0000, 64'hC014_BEEF_00AA_00AA};
    vecs[21] = '{4'b0000, 4'b0000, 40'h0, 64'h0, 4'b0000, 2'b00, 10'd0, 10'd0, 16'h0, 16'h0, 4'b0101, 64'hC014_00AA_00AA_C01E};

    // Reset held with every requester asking to write
    rstn = 1'b0;
    drive(4'b1111, 4'b1111, {10'd1, 10'd2, 10'd3, 10'd4}, 64'hFFFF_FFFF_FFFF_FFFF);
    repeat (3) @(negedge clk);
    #1;
    chk("reset ready", 64'(req_ready), 64'h0);
    chk("reset wen", 64'({sram_wen1, sram_wen0}), 64'h0);
    chk("reset rsp_valid", 64'(rsp_valid), 64'h0);
    chk("reset rsp_rdata", rsp_rdata, 64'h0);

    // Directed vector table
    @(negedge clk);
    rstn = 1'b1;
    for (int r = 0; r < int'(NVEC); r++) begin
      if (r > 0) @(negedge clk);
      drive(vecs[r].v, vecs[r].we, vecs[r].addr, vecs[r].wdata);
      #1;
      chk($sformatf("row%0d ready", r), 64'(req_ready), 64'(vecs[r].rdy));
      chk($sformatf("row%0d port0", r), 64'({sram_wen0, sram_a0, sram_d0}),
          64'({vecs[r].wen[0], vecs[r].a0, vecs[r].d0}));
      chk($sformatf("row%0d port1", r), 64'({sram_wen1, sram_a1, sram_d1}),
          64'({vecs[r].wen[1], vecs[r].a1, vecs[r].d1}));
      chk($sformatf("row%0d rsp_valid", r), 64'(rsp_valid), 64'(vecs[r].rv));
      chk($sformatf("row%0d rsp_rdata", r), rsp_rdata, vecs[r].rd);
    end

    // Reset one cycle after a read grant: the read must never respond
    @(negedge clk);
    drive(4'b0010, 4'b0000, {20'd0, 10'd9, 10'd0}, 64'h0);
    #1;
    chk("midrst grant", 64'(req_ready), 64'h2);
    @(negedge clk);
    drive(4'b0000, 4'b0000, 40'h0, 64'h0);
    rstn = 1'b0;
    #1;
    chk("midrst in reset rsp_valid", 64'(rsp_valid), 64'h0);
    @(negedge clk);
    rstn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("midrst quiet%0d rsp_valid", c), 64'(rsp_valid), 64'h0);
      chk($sformatf("midrst quiet%0d rsp_rdata", c), rsp_rdata, 64'h0);
    end
    @(negedge clk);
    drive(4'b0010, 4'b0000, {20'd0, 10'd9, 10'd0}, 64'h0);
    #1;
    chk("midrst reread grant", 64'(req_ready), 64'h2);
    @(negedge clk);
    drive(4'b0000, 4'b0000, 40'h0, 64'h0);
    @(negedge clk);
    #1;
    chk("midrst reread rsp_valid", 64'(rsp_valid), 64'h2);
    chk("midrst reread rsp_rdata", rsp_rdata, 64'h0000_0000_5555_0000);

    // Random traffic against the reference model; fresh reset aligns the pointer
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    mptr = 0;
    for (int a = 0; a < 1024; a++) rmem[a] = init_val(a);
    for (int s = 0; s < 3; s++) begin
      sv[s] = '0;
      for (int i = 0; i < 4; i++) sd[s][i] = '0;
    end
    for (int i = 0; i < 4; i++) begin
      exp_rd[i] = '0;
      pv[i]     = 1'b0;
      pwe[i]    = 1'b0;
      pa[i]     = '0;
      pd[i]     = '0;
    end

    for (int n = 0; n < int'(NRND); n++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (!pv[i] && $urandom_range(9) < 7) begin
          pv[i]  = 1'b1;
          pwe[i] = ($urandom_range(2) == 0);
          pa[i]  = 10'(512 + $urandom_range(5));
          pd[i]  = 16'($urandom);
        end
        req_valid[i]           = pv[i];
        req_we[i]              = pwe[i];
        req_addr[i*AB +: AB]   = pa[i];
        req_wdata[i*DB +: DB]  = pd[i];
      end
      #1;

      slot = n % 3;
      for (int i = 0; i < 4; i++) if (sv[slot][i]) exp_rd[i] = sd[slot][i];
      chk($sformatf("rnd%0d rsp_valid", n), 64'(rsp_valid), 64'(sv[slot]));
      chk($sformatf("rnd%0d rsp_rdata", n), rsp_rdata,
          {exp_rd[3], exp_rd[2], exp_rd[1], exp_rd[0]});
      sv[slot] = '0;

      // Waiting requesters in rotation order from the pointer
      waitq.delete();
      for (int k = 0; k < 4; k++) if (pv[(mptr + k) % 4]) waitq.push_back((mptr + k) % 4);
      g0m = -1;
      g1m = -1;
      if (waitq.size() > 0) begin
        g0m = waitq.pop_front();
        foreach (waitq[j]) begin
          if (g1m < 0 && !(pa[waitq[j]] == pa[g0m] && (pwe[waitq[j]] || pwe[g0m])))
            g1m = waitq[j];
        end
      end
      exp_rdy = '0;
      if (g0m >= 0) exp_rdy[g0m] = 1'b1;
      if (g1m >= 0) exp_rdy[g1m] = 1'b1;
      chk($sformatf("rnd%0d ready", n), 64'(req_ready), 64'(exp_rdy));
      chk($sformatf("rnd%0d port0", n), 64'({sram_wen0, sram_a0, sram_d0}),
          (g0m >= 0) ? 64'({pwe[g0m], pa[g0m], pd[g0m]}) : 64'h0);
      chk($sformatf("rnd%0d port1", n), 64'({sram_wen1, sram_a1, sram_d1}),
          (g1m >= 0) ? 64'({pwe[g1m], pa[g1m], pd[g1m]}) : 64'h0);

      ns = (n + 2) % 3;
      if (g0m >= 0 && !pwe[g0m]) begin sv[ns][g0m] = 1'b1; sd[ns][g0m] = rmem[pa[g0m]]; end
      if (g1m >= 0 && !pwe[g1m]) begin sv[ns][g1m] = 1'b1; sd[ns][g1m] = rmem[pa[g1m]]; end
      if (g0m >= 0 && pwe[g0m]) rmem[pa[g0m]] = pd[g0m];
      if (g1m >= 0 && pwe[g1m]) rmem[pa[g1m]] = pd[g1m];
      if (g0m >= 0) begin pv[g0m] = 1'b0; mptr = (g0m + 1) % 4; end
      if (g1m >= 0) pv[g1m] = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
